// File: rtl/axi_read_arbiter_pkg.sv
// ============================================================================
// axi_read_arbiter_pkg : shared AXI constants, requester ids and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_read_arbiter_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int unsigned ID_INST = 0;
   localparam int unsigned ID_DATA = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/axi_read_arbiter_if.sv
// ============================================================================
// axi_read_arbiter_if : requester-side and AXI-side read signals of the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_read_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) ();

   logic              inst_arvalid;
   logic              inst_arready;
   logic [ADDR_W-1:0] inst_araddr;
   logic [7:0]        inst_arlen;
   logic [2:0]        inst_arsize;
   logic              inst_rvalid;
   logic              inst_rready;

   logic              data_arvalid;
   logic              data_arready;
   logic [ADDR_W-1:0] data_araddr;
   logic [7:0]        data_arlen;
   logic [2:0]        data_arsize;
   logic              data_rvalid;
   logic              data_rready;

   logic [DATA_W-1:0] req_rdata;
   logic [1:0]        req_rresp;
   logic              req_rlast;

   logic [ID_W-1:0]   arid;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              arvalid;
   logic              arready;
   logic [ID_W-1:0]   rid;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic              rvalid;
   logic              rready;

   logic              protocol_err;

   // The arbiter is the AXI master towards the pins.
   modport master (
      input  inst_arvalid, inst_araddr, inst_arlen, inst_arsize, inst_rready,
      input  data_arvalid, data_araddr, data_arlen, data_arsize, data_rready,
      input  arready, rid, rdata, rresp, rlast, rvalid,
      output inst_arready, inst_rvalid, data_arready, data_rvalid,
      output req_rdata, req_rresp, req_rlast,
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output protocol_err
   );

   modport slave (
      output inst_arvalid, inst_araddr, inst_arlen, inst_arsize, inst_rready,
      output data_arvalid, data_araddr, data_arlen, data_arsize, data_rready,
      output arready, rid, rdata, rresp, rlast, rvalid,
      input  inst_arready, inst_rvalid, data_arready, data_rvalid,
      input  req_rdata, req_rresp, req_rlast,
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  protocol_err
   );

endinterface

`default_nettype wire

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way round-robin picker; req[0]=inst, req[1]=data
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] gnt
);

   // 0 = inst won last, 1 = data won last
   logic last_grant_q;
   logic last_grant_d;

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (update && (gnt != 2'b00)) begin
         last_grant_d = gnt[1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/axi_read_arbiter.sv
// ============================================================================
// axi_read_arbiter : shares one AXI read channel between icache and dcache
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_read_arbiter
   import axi_read_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 4
) (
   input  logic               clock,
   input  logic               reset,
   axi_read_arbiter_if.master bus
);

   state_t            state_q,    state_d;
   logic [ID_W-1:0]   arid_q,     arid_d;
   logic [ADDR_W-1:0] araddr_q,   araddr_d;
   logic [7:0]        arlen_q,    arlen_d;
   logic [2:0]        arsize_q,   arsize_d;
   logic [7:0]        beat_cnt_q, beat_cnt_d;
   logic              err_q,      err_d;

   logic [1:0] gnt;
   logic       grant_en;
   logic       owner_data;
   logic       owner_rready;
   logic       inst_arready, data_arready, inst_rvalid, data_rvalid, arvalid;

   rr_arbiter2 u_rr (
      .clock  (clock),
      .reset  (reset),
      .req    ({bus.data_arvalid, bus.inst_arvalid}),
      .update (grant_en),
      .gnt    (gnt)
   );

   assign owner_data = (arid_q == ID_W'(ID_DATA));

   always_comb begin
      state_d      = state_q;
      arid_d       = arid_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arsize_d     = arsize_q;
      beat_cnt_d   = beat_cnt_q;
      err_d        = err_q;
      grant_en     = 1'b0;
      inst_arready = 1'b0;
      data_arready = 1'b0;
      inst_rvalid  = 1'b0;
      data_rvalid  = 1'b0;
      arvalid      = 1'b0;
      owner_rready = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt != 2'b00) begin
               grant_en     = 1'b1;
               inst_arready = gnt[0];
               data_arready = gnt[1];
               arid_d       = gnt[1] ? ID_W'(ID_DATA) : ID_W'(ID_INST);
               araddr_d     = gnt[1] ? bus.data_araddr : bus.inst_araddr;
               arlen_d      = gnt[1] ? bus.data_arlen  : bus.inst_arlen;
               arsize_d     = gnt[1] ? bus.data_arsize : bus.inst_arsize;
               beat_cnt_d   = 8'd0;
               state_d      = ADDR;
            end
         end
         ADDR: begin
            arvalid = 1'b1;
            if (bus.arready) begin
               state_d = DATA;
            end
         end
         DATA: begin
            owner_rready = owner_data ? bus.data_rready : bus.inst_rready;
            inst_rvalid  = !owner_data && bus.rvalid;
            data_rvalid  = owner_data && bus.rvalid;
            if (bus.rvalid && owner_rready) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               // Bad beats are still forwarded; only rlast ends the burst.
               if ((bus.rid != arid_q) || (bus.rlast != (beat_cnt_q == arlen_q))) begin
                  err_d = 1'b1;
               end
               if (bus.rlast) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         arid_q     <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         arid_q     <= arid_d;
         araddr_q   <= araddr_d;
         arlen_q    <= arlen_d;
         arsize_q   <= arsize_d;
         beat_cnt_q <= beat_cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.inst_arready = inst_arready;
   assign bus.data_arready = data_arready;
   assign bus.inst_rvalid  = inst_rvalid;
   assign bus.data_rvalid  = data_rvalid;
   assign bus.arvalid      = arvalid;
   assign bus.rready       = owner_rready;
   assign bus.arid         = arid_q;
   assign bus.araddr       = araddr_q;
   assign bus.arlen        = arlen_q;
   assign bus.arsize       = arsize_q;
   assign bus.arburst      = BURST_INCR;
   assign bus.req_rdata    = bus.rdata;
   assign bus.req_rresp    = bus.rresp;
   assign bus.req_rlast    = bus.rlast;
   assign bus.protocol_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
// ============================================================================
// tb_axi_read_arbiter : directed self-checking bench for axi_read_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axi_read_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   axi_read_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

   axi_read_arbiter #(.ADDR_W(32), .ID_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
   endtask

   task automatic drive_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic sample();
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      bus.inst_arvalid = 0; bus.inst_araddr = '0; bus.inst_arlen = '0; bus.inst_arsize = '0;
      bus.data_arvalid = 0; bus.data_araddr = '0; bus.data_arlen = '0; bus.data_arsize = '0;
      bus.inst_rready  = 1; bus.data_rready = 1;
      bus.arready = 0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 0; bus.rvalid = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      idle_inputs();
      drive_edge();
      drive_edge();
      reset = 0;
   endtask

   task automatic request(input bit is_data, input logic [31:0] addr, input logic [7:0] len);
      if (is_data) begin
         bus.data_arvalid = 1; bus.data_araddr = addr; bus.data_arlen = len; bus.data_arsize = 3'd3;
      end else begin
         bus.inst_arvalid = 1; bus.inst_araddr = addr; bus.inst_arlen = len; bus.inst_arsize = 3'd2;
      end
   endtask

   // Waits (bounded) for a grant pulse and checks who won and how long it took.
   task automatic expect_grant(input bit exp_data, input int exp_wait, input string tag);
      int waited = 0;
      bit got    = 0;
      while (!got && waited < 8) begin
         sample();
         if (bus.inst_arready || bus.data_arready) begin
            check({tag, "_onehot"}, 64'(bus.inst_arready & bus.data_arready), 0);
            check({tag, "_winner_is_data"}, 64'(bus.data_arready), 64'(exp_data));
            check({tag, "_arvalid_in_grant"}, 64'(bus.arvalid), 0);
            got = 1;
         end else begin
            waited++;
         end
         drive_edge();
      end
      check({tag, "_wait"}, 64'(waited), 64'(exp_wait));
   endtask

   // Called right after the grant edge: acts as slave for AR and R of one burst.
   task automatic serve(input bit is_data, input logic [31:0] exp_addr, input logic [7:0] exp_len,
                        input int last_at, input logic [3:0] rid_v, input int ar_wait,
                        input int stall_beat, input int stall_n);
      logic [31:0] pat;
      bus.arready = 0;
      for (int w = 0; w <= ar_wait; w++) begin
         if (w == ar_wait) bus.arready = 1;
         sample();
         check("arvalid", 64'(bus.arvalid), 1);
         if (w == 0) begin
            check("arid",    64'(bus.arid),    is_data ? 64'd1 : 64'd0);
            check("araddr",  64'(bus.araddr),  64'(exp_addr));
            check("arlen",   64'(bus.arlen),   64'(exp_len));
            check("arsize",  64'(bus.arsize),  is_data ? 64'd3 : 64'd2);
            check("arburst", 64'(bus.arburst), 64'd1);
         end
         drive_edge();
      end
      bus.arready = 0;
      for (int b = 0; b <= last_at; b++) begin
         pat = 32'hA500_0000 | 32'(b) | (is_data ? 32'h0000_0100 : 32'h0);
         bus.rvalid = 1; bus.rid = rid_v; bus.rdata = pat;
         bus.rresp = pat[1:0]; bus.rlast = (b == last_at);
         if (b == stall_beat) begin
            if (is_data) bus.data_rready = 0; else bus.inst_rready = 0;
            for (int s = 0; s < stall_n; s++) begin
               sample();
               check("stall_rready", 64'(bus.rready), 0);
               check("stall_owner_rvalid", 64'(is_data ? bus.data_rvalid : bus.inst_rvalid), 1);
               drive_edge();
            end
            bus.data_rready = 1; bus.inst_rready = 1;
         end
         sample();
         check("beat_rready",       64'(bus.rready), 1);
         check("beat_owner_rvalid", 64'(is_data ? bus.data_rvalid : bus.inst_rvalid), 1);
         check("beat_other_rvalid", 64'(is_data ? bus.inst_rvalid : bus.data_rvalid), 0);
         check("beat_rdata",        64'(bus.req_rdata), 64'(pat));
         check("beat_rresp",        64'(bus.req_rresp), 64'(pat[1:0]));
         check("beat_rlast",        64'(bus.req_rlast), 64'(b == last_at));
         check("beat_no_arready",   64'({bus.inst_arready, bus.data_arready}), 0);
         drive_edge();
      end
      bus.rvalid = 0; bus.rlast = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state
      do_reset();
      sample();
      check("rst_arvalid",  64'(bus.arvalid), 0);
      check("rst_rready",   64'(bus.rready), 0);
      check("rst_arready",  64'({bus.inst_arready, bus.data_arready}), 0);
      check("rst_rvalid",   64'({bus.inst_rvalid, bus.data_rvalid}), 0);
      check("rst_err",      64'(bus.protocol_err), 0);
      check("rst_arfields", 64'({bus.arid, bus.araddr, bus.arlen, bus.arsize}), 0);
      drive_edge();

      // Single icache burst, slave arready after 2 cycles
      request(0, 32'h1FC0_0000, 8'd7);
      expect_grant(0, 0, "t1_grant");
      bus.inst_arvalid = 0;
      serve(0, 32'h1FC0_0000, 8'd7, 7, 4'd0, 1, -1, 0);
      sample();
      check("t1_idle_arvalid", 64'(bus.arvalid), 0);
      check("t1_idle_rready",  64'(bus.rready), 0);
      check("t1_err",          64'(bus.protocol_err), 0);
      drive_edge();

      // Simultaneous requests after reset, then six alternating bursts
      do_reset();
      request(0, 32'h1FC0_0100, 8'd3);
      request(1, 32'h8000_0040, 8'd0);
      for (int k = 0; k < 6; k++) begin
         if ((k % 2) == 0) begin
            expect_grant(1, 0, "rr_grant_d");
            if (k == 5) begin bus.inst_arvalid = 0; bus.data_arvalid = 0; end
            serve(1, 32'h8000_0040, 8'd0, 0, 4'd1, 0, -1, 0);
         end else begin
            expect_grant(0, 0, "rr_grant_i");
            if (k == 5) begin bus.inst_arvalid = 0; bus.data_arvalid = 0; end
            serve(0, 32'h1FC0_0100, 8'd3, 3, 4'd0, 0, -1, 0);
         end
      end
      sample();
      check("rr_err", 64'(bus.protocol_err), 0);
      drive_edge();

      // Owner backpressure: three stall cycles on beat 1
      do_reset();
      request(1, 32'h8000_1000, 8'd3);
      expect_grant(1, 0, "bp_grant");
      bus.data_arvalid = 0;
      serve(1, 32'h8000_1000, 8'd3, 3, 4'd1, 0, 1, 3);
      sample();
      check("bp_err", 64'(bus.protocol_err), 0);
      drive_edge();

      // Early rlast, then a later rid mismatch keeps the flag set
      do_reset();
      request(0, 32'h1FC0_2000, 8'd3);
      expect_grant(0, 0, "er_grant");
      bus.inst_arvalid = 0;
      serve(0, 32'h1FC0_2000, 8'd3, 1, 4'd0, 0, -1, 0);
      sample();
      check("er_err_set",   64'(bus.protocol_err), 1);
      check("er_idle",      64'(bus.arvalid), 0);
      drive_edge();
      request(1, 32'h8000_2000, 8'd1);
      expect_grant(1, 0, "er_grant2");
      bus.data_arvalid = 0;
      serve(1, 32'h8000_2000, 8'd1, 1, 4'd5, 0, -1, 0);
      sample();
      check("er_err_sticky", 64'(bus.protocol_err), 1);
      drive_edge();

      // rid mismatch alone
      do_reset();
      request(1, 32'h8000_3000, 8'd1);
      expect_grant(1, 0, "rid_grant");
      bus.data_arvalid = 0;
      serve(1, 32'h8000_3000, 8'd1, 1, 4'd7, 0, -1, 0);
      sample();
      check("rid_err", 64'(bus.protocol_err), 1);
      drive_edge();

      // Missing rlast on the final counted beat
      do_reset();
      request(0, 32'h1FC0_3000, 8'd1);
      expect_grant(0, 0, "late_grant");
      bus.inst_arvalid = 0;
      serve(0, 32'h1FC0_3000, 8'd1, 2, 4'd0, 0, -1, 0);
      sample();
      check("late_err", 64'(bus.protocol_err), 1);
      drive_edge();

      // Reset in DATA after 2 of 4 beats
      do_reset();
      request(0, 32'h1FC0_4000, 8'd3);
      expect_grant(0, 0, "mr_grant");
      bus.inst_arvalid = 0;
      bus.arready = 1;
      sample();
      drive_edge();
      bus.arready = 0;
      for (int b = 0; b < 2; b++) begin
         bus.rvalid = 1; bus.rid = 4'd9; bus.rdata = 32'(b); bus.rlast = 0;
         sample();
         drive_edge();
      end
      bus.rvalid = 0;
      sample();
      check("mr_err_before", 64'(bus.protocol_err), 1);
      reset = 1;
      bus.rvalid = 1;
      drive_edge();
      reset = 0;
      sample();
      check("mr_arvalid", 64'(bus.arvalid), 0);
      check("mr_rready",  64'(bus.rready), 0);
      check("mr_rvalid",  64'({bus.inst_rvalid, bus.data_rvalid}), 0);
      check("mr_err",     64'(bus.protocol_err), 0);
      check("mr_fields",  64'({bus.arid, bus.araddr, bus.arlen}), 0);
      drive_edge();
      bus.rvalid = 0;
      request(0, 32'h1FC0_5000, 8'd1);
      expect_grant(0, 0, "mr_regrant");
      bus.inst_arvalid = 0;
      serve(0, 32'h1FC0_5000, 8'd1, 1, 4'd0, 0, -1, 0);
      sample();
      check("mr_final_err", 64'(bus.protocol_err), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the core's single AXI read channel (ar/r) between instruction-cache and data-cache refill requesters.
- One outstanding burst at a time; round-robin grant; R beats steered back to the owner.
- Checks burst length against rlast and flags violations for soc-simulator debug.
- Sits between the cache refill units and the top-level AXI ar*/r* pins.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
ID_W, 4, AXI id width; arid = 0 for inst, 1 for data

Ports:
clock  in  1  sole clock
reset  in  1  synchronous, active-high
inst_arvalid  in  1  icache read request
inst_arready  out  1  icache request accepted (grant pulse)
inst_araddr  in  ADDR_W  icache burst address
inst_arlen  in  8  icache beats-1
inst_arsize  in  3  icache beat size
inst_rvalid  out  1  beat valid to icache
inst_rready  in  1  icache accepts beat
data_arvalid  in  1  dcache/uncached read request
data_arready  out  1  dcache request accepted
data_araddr  in  ADDR_W  dcache address
data_arlen  in  8  dcache beats-1
data_arsize  in  3  dcache beat size
data_rvalid  out  1  beat valid to dcache
data_rready  in  1  dcache accepts beat
req_rdata  out  DATA_W  shared beat data (qualified by *_rvalid)
req_rresp  out  2  shared beat response
req_rlast  out  1  shared last-beat flag
arid  out  ID_W  granted requester id
araddr  out  ADDR_W  latched address
arlen  out  8  latched length
arsize  out  3  latched size
arburst  out  2  constant 2'b01 (INCR)
arvalid  out  1  AR valid
arready  in  1  AR ready
rid  in  ID_W  R id
rdata  in  DATA_W  R data
rresp  in  2  R response
rlast  in  1  R last
rvalid  in  1  R valid
rready  out  1  R ready
protocol_err  out  1  sticky burst/id mismatch flag

Behaviour:
- Reset values: state IDLE; arvalid, rready, inst/data_arready, inst/data_rvalid, protocol_err = 0; arid/araddr/arlen/arsize = 0; last_grant = inst.
- FSM IDLE:
  - Neither valid: stay.
  - One valid: grant it.
  - Both valid: grant the one not equal to last_grant (first tie after reset goes to data).
  - Grant cycle: assert that requester's *_arready combinationally for exactly one cycle, latch addr/len/size, set arid, beat_cnt = 0, last_grant = winner, go to ADDR.
  - At most one *_arready is high in any cycle.
- ADDR:
  - arvalid = 1 with latched fields, held stable until arready.
  - arvalid & arready: go to DATA next cycle.
- DATA:
  - rready = owner's *_rready.
  - Owner's *_rvalid = rvalid; other requester's rvalid = 0.
  - req_rdata/rresp/rlast = rdata/rresp/rlast, combinational.
  - Each rvalid & rready handshake increments beat_cnt (8-bit).
  - Handshake with rlast = 1: go to IDLE. The next grant can occur in the following cycle, not the same one (minimum 1 idle cycle between bursts).
- Latency: request to arvalid = 1 cycle; rvalid to owner rvalid = 0 cycles.
- protocol_err: set (sticky until reset) on a DATA-state handshake when any of these holds:
  - rid != arid;
  - rlast = 1 with beat_cnt != arlen;
  - rlast = 0 with beat_cnt == arlen.
  - The beat is still forwarded; the FSM still exits only on rlast.
- rresp is not interpreted; SLVERR/DECERR is passed through.
- rvalid in IDLE/ADDR: ignored, rready = 0.
- Requester-side rules:
  - A requester may drop arvalid before its grant; the arbiter samples only the current cycle.
  - A granted requester must keep *_rready asserted or stall; stalls propagate to rready.
- Reset mid-burst: next cycle state = IDLE and all outputs at reset values. The outstanding transaction is abandoned (the SoC resets the slave simultaneously).

Decomposition:
- Shared package: AXI constants (BURST_INCR = 2'b01, RESP codes), requester id constants (ID_INST = 0, ID_DATA = 1), FSM state enum {IDLE, ADDR, DATA}.
- One natural sub-module: rr_arbiter2 (2-way round-robin picker with last_grant register and update enable).

Test Plan:
- Single icache burst: inst_araddr=0x1FC00000, arlen=7, slave arready after 2 cycles, 8 beats, rid=0 -> arvalid held 2 cycles with araddr=0x1FC00000/arid=0; inst_rvalid on all 8 beats; data_rvalid=0; back to IDLE after rlast; protocol_err=0.
- Simultaneous requests after reset, inst len 3 and data len 0, both held -> data granted first (arid=1), then inst (arid=0) after data's rlast plus 1 idle cycle; inst_arready and data_arready never high together.
- Continuous requests from both for 6 bursts -> grants alternate D,I,D,I,D,I.
- Owner backpressure: data_rready low for 3 cycles mid-burst with rvalid high -> rready low for those 3 cycles; no beat lost; beat_cnt correct at rlast.
- Error: arlen=3 but slave asserts rlast on beat 2 (beat_cnt=1) -> protocol_err rises the cycle after that beat and stays 1; FSM returns to IDLE. rid=5 on a later beat of a new burst -> protocol_err remains 1.
- Reset asserted in DATA after 2 of 4 beats -> next cycle arvalid=0, rready=0, state IDLE, protocol_err=0; a new inst request after reset is granted normally.
